pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  5-stage-pipeline successor to the single-cycle control decoder. Decodes Op_i in ID.
//  Carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
//  Detects load-use hazards and inserts bubbles, and flushes on jump or taken branch.
//  Keeps a saturating stall counter. Sits between the IF/ID register and the datapath stage muxes.
// PARAMETERS
//  REG_AW       5   register-address width (Rs/Rt/Rd/dest)
//  SUPPORT_BNE  1   1: decode bne (6'b000101) as branch-not-equal; 0: illegal
//  SUPPORT_ORI  1   1: decode ori (6'b001101), zero-extend, ALUOp=3; 0: illegal
//  CNT_W        16  stall-counter width
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_i           in   1       asynchronous, active-high reset
//  Op_i            in   6       opcode of instruction in ID
//  Rs_i,Rt_i,Rd_i  in   REG_AW  register fields of instruction in ID
//  BrTaken_i       in   1       EX comparator: branch now in EX is taken
//  Jump_o          out  1       comb: ID holds j (6'b000010)
//  ExtOp_o         out  1       comb: 1 sign-extend, 0 zero-extend (ori only)
//  Stall_o         out  1       comb: hold PC and IF/ID
//  Flush_o         out  1       comb: zero IF/ID on next edge
//  IllegalOp_o     out  1       comb: undecodable opcode in ID
//  EX_ALUSrc_o,EX_RegDst_o,EX_Branch_o,EX_BranchNe_o  out 1  registered ID/EX
//  EX_ALUOp_o      out  2       0 R-type(funct), 1 add, 2 sub, 3 or
//  MEM_MemRead_o,MEM_MemWrite_o  out 1  registered EX/MEM
//  WB_RegWrite_o,WB_MemtoReg_o   out 1  registered MEM/WB
//  WB_WriteReg_o   out  REG_AW  destination register in WB
//  StallCnt_o      out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  Decode (comb):
//   R 000000: RegDst=1, RegWrite=1, ALUOp=0.
//   lw 100011: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=1.
//   sw 101011: ALUSrc=1, MemWrite=1, ALUOp=1.
//   addi 001000: ALUSrc=1, RegWrite=1, ALUOp=1.
//   beq 000100: Branch=1, ALUOp=2. bne: Branch=1, BranchNe=1, ALUOp=2.
//   ori: ALUSrc=1, RegWrite=1, ALUOp=3, ExtOp=0.
//   j: Jump=1, bundle all-zero.
//   Other opcodes: bundle all-zero, IllegalOp_o=1.
//   ExtOp_o=1 for all opcodes except ori.
//  Dest: Rd_i if RegDst else Rt_i; carried with the bundle. Dest 0 never writes (RegWrite forced 0).
//  Load-use: Stall_o = EX_MemRead & (ex_dest!=0) & (ex_dest==Rs_i | ex_dest==Rt_i).
//   On stall, ID/EX loads the all-zero bubble; decode of the held instruction repeats next cycle.
//  Flush: Flush_o = BrTaken_i | Jump_o.
//   BrTaken_i also loads a bubble into ID/EX (kills the wrong-path ID instruction).
//   When BrTaken_i is set, Stall_o is forced 0.
//  Priority: BrTaken_i > load-use stall > jump > normal advance.
//   Jump together with a stall: Stall_o=1, Flush_o=0; the jump re-decodes next cycle.
//  EX/MEM and MEM/WB always advance; no back-pressure.
//  Latency: ID-decoded fields appear at EX_* 1 cycle later, MEM_* 2, WB_* 3.
//  StallCnt_o: +1 each cycle Stall_o=1, saturates at all-ones, never wraps.
//  Reset (async, any time, mid-stall included): every registered output and StallCnt_o = 0.
//   Pipeline is bubble-filled; comb outputs follow the inputs immediately.
// STRUCTURE
//  Package pipe_ctrl_pkg: opcode localparams, ALUOP_* constants, ctrl_bundle_t struct
//   {ALUSrc, RegDst, Branch, BranchNe, ALUOp, MemRead, MemWrite, RegWrite, MemtoReg}
//   and the CTRL_BUBBLE constant.
//  Sub-module ctrl_decode: purely combinational Op_i -> ctrl_bundle_t, ExtOp, Jump, IllegalOp,
//   honouring SUPPORT_*. Hazard logic, stage registers and counter stay in the top.
// TESTING
//  1 lw $t0(Rt=8); next add Rs=8 -> Stall_o=1 one cycle, EX bundle zero, StallCnt_o=1;
//    add reaches WB 1 cycle late with WB_WriteReg_o=Rd.
//  2 lw Rt=0 then use Rs=0 -> no stall; lw WB_RegWrite_o=0.
//  3 beq in EX with BrTaken_i=1 while ID has lw-use hazard -> Flush_o=1, Stall_o=0, next EX bubble.
//  4 Op 001101 with SUPPORT_ORI=0 -> IllegalOp_o=1, zero bundle; SUPPORT_ORI=1 -> ExtOp_o=0, EX_ALUOp_o=3.
//  5 CNT_W=2, 5 consecutive stalls -> StallCnt_o sequence 1,2,3,3,3.
//  6 Assert rst_i mid-stall with pipeline full -> all EX_/MEM_/WB_ outputs and StallCnt_o 0
//    before the next clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcodes, ALU-op codes and the control bundle for the pipelined control unit
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_FUNCT = 2'd0;
    localparam logic [1:0] ALUOP_ADD   = 2'd1;
    localparam logic [1:0] ALUOP_SUB   = 2'd2;
    localparam logic [1:0] ALUOP_OR    = 2'd3;

    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       branch_ne;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       memto_reg;
    } ctrl_bundle_t;

    // A bubble is a no-op: nothing written, nothing accessed.
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decoder for the pipelined control unit
//
// Ports:
//   op          in   opcode of the instruction in ID
//   ctrl        out  control bundle (all-zero for j and for illegal opcodes)
//   ext_op      out  1 sign-extend immediate, 0 zero-extend (ori)
//   jump        out  opcode is j
//   illegal_op  out  opcode not decodable with the enabled instruction set
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1,
    parameter bit SUPPORT_ORI = 1'b1
) (
    input  logic [5:0]   op,
    output ctrl_bundle_t ctrl,
    output logic         ext_op,
    output logic         jump,
    output logic         illegal_op
);

    always_comb begin
        ctrl       = CTRL_BUBBLE;
        ext_op     = 1'b1;
        jump       = 1'b0;
        illegal_op = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.memto_reg = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            OP_BNE: begin
                if (SUPPORT_BNE) begin
                    ctrl.branch    = 1'b1;
                    ctrl.branch_ne = 1'b1;
                    ctrl.alu_op    = ALUOP_SUB;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            OP_ORI: begin
                if (SUPPORT_ORI) begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_OR;
                    ext_op         = 1'b0;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: begin
                illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - 5-stage pipeline control: decode, ID/EX/MEM/WB control registers, hazards
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), asynchronous active-high reset
//   Op_i, Rs_i, Rt_i, Rd_i       instruction fields held in IF/ID
//   BrTaken_i                    branch currently in EX resolves taken
//   Jump_o, ExtOp_o, IllegalOp_o combinational decode of the ID instruction
//   Stall_o                      hold PC and IF/ID (load-use hazard)
//   Flush_o                      clear IF/ID on the next edge (taken branch or jump)
//   EX_*                         ID/EX control register
//   MEM_MemRead_o, MEM_MemWrite_o EX/MEM control register
//   WB_RegWrite_o, WB_MemtoReg_o, WB_WriteReg_o  MEM/WB control register
//   StallCnt_o                   saturating count of stall cycles
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter bit SUPPORT_BNE = 1'b1,
    parameter bit SUPPORT_ORI = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        Op_i,
    input  logic [REG_AW-1:0] Rs_i,
    input  logic [REG_AW-1:0] Rt_i,
    input  logic [REG_AW-1:0] Rd_i,
    input  logic              BrTaken_i,
    output logic              Jump_o,
    output logic              ExtOp_o,
    output logic              Stall_o,
    output logic              Flush_o,
    output logic              IllegalOp_o,
    output logic              EX_ALUSrc_o,
    output logic              EX_RegDst_o,
    output logic              EX_Branch_o,
    output logic              EX_BranchNe_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic              MEM_MemRead_o,
    output logic              MEM_MemWrite_o,
    output logic              WB_RegWrite_o,
    output logic              WB_MemtoReg_o,
    output logic [REG_AW-1:0] WB_WriteReg_o,
    output logic [CNT_W-1:0]  StallCnt_o
);

    ctrl_bundle_t      dec_ctrl;
    ctrl_bundle_t      id_ctrl;
    logic [REG_AW-1:0] id_dest;

    ctrl_bundle_t      ex_ctrl;
    logic [REG_AW-1:0] ex_dest;

    logic              mem_read;
    logic              mem_write;
    logic              mem_reg_write;
    logic              mem_memto_reg;
    logic [REG_AW-1:0] mem_dest;

    logic              wb_reg_write;
    logic              wb_memto_reg;
    logic [REG_AW-1:0] wb_dest;

    logic              load_use;
    logic              bubble;
    logic [CNT_W-1:0]  stall_cnt;

    ctrl_decode #(
        .SUPPORT_BNE (SUPPORT_BNE),
        .SUPPORT_ORI (SUPPORT_ORI)
    ) u_decode (
        .op         (Op_i),
        .ctrl       (dec_ctrl),
        .ext_op     (ExtOp_o),
        .jump       (Jump_o),
        .illegal_op (IllegalOp_o)
    );

    // Register 0 is hard-wired, so a write to it is dropped here rather than in the register file.
    always_comb begin
        id_ctrl = dec_ctrl;
        id_dest = dec_ctrl.reg_dst ? Rd_i : Rt_i;
        if (id_dest == '0) begin
            id_ctrl.reg_write = 1'b0;
        end
    end

    // The hazard compares against Rs/Rt regardless of whether the ID instruction reads them;
    // an occasional unnecessary stall is cheaper than per-opcode source tracking.
    assign load_use = ex_ctrl.mem_read && (ex_dest != '0) &&
                      ((ex_dest == Rs_i) || (ex_dest == Rt_i));

    // A taken branch kills the ID instruction anyway, so stalling it would be pointless.
    assign Stall_o = load_use && !BrTaken_i;
    // A jump held by a stall must not flush: the jump itself is still in IF/ID.
    assign Flush_o = BrTaken_i || (Jump_o && !load_use);
    assign bubble  = BrTaken_i || load_use;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_ctrl       <= CTRL_BUBBLE;
            ex_dest       <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_memto_reg <= 1'b0;
            mem_dest      <= '0;
            wb_reg_write  <= 1'b0;
            wb_memto_reg  <= 1'b0;
            wb_dest       <= '0;
            stall_cnt     <= '0;
        end else begin
            if (bubble) begin
                ex_ctrl <= CTRL_BUBBLE;
                ex_dest <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_dest <= id_dest;
            end
            mem_read      <= ex_ctrl.mem_read;
            mem_write     <= ex_ctrl.mem_write;
            mem_reg_write <= ex_ctrl.reg_write;
            mem_memto_reg <= ex_ctrl.memto_reg;
            mem_dest      <= ex_dest;
            wb_reg_write  <= mem_reg_write;
            wb_memto_reg  <= mem_memto_reg;
            wb_dest       <= mem_dest;
            if (Stall_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign EX_ALUSrc_o    = ex_ctrl.alu_src;
    assign EX_RegDst_o    = ex_ctrl.reg_dst;
    assign EX_Branch_o    = ex_ctrl.branch;
    assign EX_BranchNe_o  = ex_ctrl.branch_ne;
    assign EX_ALUOp_o     = ex_ctrl.alu_op;
    assign MEM_MemRead_o  = mem_read;
    assign MEM_MemWrite_o = mem_write;
    assign WB_RegWrite_o  = wb_reg_write;
    assign WB_MemtoReg_o  = wb_memto_reg;
    assign WB_WriteReg_o  = wb_dest;
    assign StallCnt_o     = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit (full and reduced configurations)
module tb_pipe_ctrl_unit;

    localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic br;

    always #5 clk = ~clk;

    // dut0: full instruction set, 16-bit counter. dut1: no bne/ori, 2-bit counter.
    logic a_jump, a_ext, a_stall, a_flush, a_ill, a_alusrc, a_regdst, a_branch, a_bne;
    logic [1:0] a_aluop;
    logic a_mr, a_mw, a_rw, a_m2r;
    logic [4:0] a_wreg;
    logic [15:0] a_cnt;
    logic b_jump, b_ext, b_stall, b_flush, b_ill, b_alusrc, b_regdst, b_branch, b_bne;
    logic [1:0] b_aluop;
    logic b_mr, b_mw, b_rw, b_m2r;
    logic [4:0] b_wreg;
    logic [1:0] b_cnt;

    pipe_ctrl_unit #(.REG_AW(5), .SUPPORT_BNE(1'b1), .SUPPORT_ORI(1'b1), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .Rs_i(rs), .Rt_i(rt), .Rd_i(rd), .BrTaken_i(br),
        .Jump_o(a_jump), .ExtOp_o(a_ext), .Stall_o(a_stall), .Flush_o(a_flush), .IllegalOp_o(a_ill),
        .EX_ALUSrc_o(a_alusrc), .EX_RegDst_o(a_regdst), .EX_Branch_o(a_branch),
        .EX_BranchNe_o(a_bne), .EX_ALUOp_o(a_aluop), .MEM_MemRead_o(a_mr), .MEM_MemWrite_o(a_mw),
        .WB_RegWrite_o(a_rw), .WB_MemtoReg_o(a_m2r), .WB_WriteReg_o(a_wreg), .StallCnt_o(a_cnt));

    pipe_ctrl_unit #(.REG_AW(5), .SUPPORT_BNE(1'b0), .SUPPORT_ORI(1'b0), .CNT_W(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .Rs_i(rs), .Rt_i(rt), .Rd_i(rd), .BrTaken_i(br),
        .Jump_o(b_jump), .ExtOp_o(b_ext), .Stall_o(b_stall), .Flush_o(b_flush), .IllegalOp_o(b_ill),
        .EX_ALUSrc_o(b_alusrc), .EX_RegDst_o(b_regdst), .EX_Branch_o(b_branch),
        .EX_BranchNe_o(b_bne), .EX_ALUOp_o(b_aluop), .MEM_MemRead_o(b_mr), .MEM_MemWrite_o(b_mw),
        .WB_RegWrite_o(b_rw), .WB_MemtoReg_o(b_m2r), .WB_WriteReg_o(b_wreg), .StallCnt_o(b_cnt));

    wire [19:0] obs0 = {a_jump, a_ext, a_stall, a_flush, a_ill, a_alusrc, a_regdst, a_branch, a_bne,
                        a_aluop, a_mr, a_mw, a_rw, a_m2r, a_wreg};
    wire [19:0] obs1 = {b_jump, b_ext, b_stall, b_flush, b_ill, b_alusrc, b_regdst, b_branch, b_bne,
                        b_aluop, b_mr, b_mw, b_rw, b_m2r, b_wreg};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One record per instruction in flight; st[i][0]=EX, [1]=MEM, [2]=WB.
    typedef struct packed {
        bit alusrc, regdst, branch, bne;
        bit [1:0] aluop;
        bit mr, mw, rw, m2r;
        bit [4:0] dest;
        bit ext, jmp, ill;
    } m_t;

    m_t st [2][3];
    int unsigned cnt [2];

    function automatic m_t dec_m(int i);
        m_t m;
        bit full;
        full = (i == 0);
        m = '0;
        m.ext = 1'b1;
        case (op)
            R:    begin m.regdst = 1; m.rw = 1; end
            LW:   begin m.alusrc = 1; m.mr = 1; m.m2r = 1; m.rw = 1; m.aluop = 2'd1; end
            SW:   begin m.alusrc = 1; m.mw = 1; m.aluop = 2'd1; end
            ADDI: begin m.alusrc = 1; m.rw = 1; m.aluop = 2'd1; end
            BEQ:  begin m.branch = 1; m.aluop = 2'd2; end
            BNE:  if (full) begin m.branch = 1; m.bne = 1; m.aluop = 2'd2; end else m.ill = 1;
            ORI:  if (full) begin m.alusrc = 1; m.rw = 1; m.aluop = 2'd3; m.ext = 0; end else m.ill = 1;
            J:    m.jmp = 1;
            default: m.ill = 1;
        endcase
        m.dest = m.regdst ? rd : rt;
        if (m.dest == 0) m.rw = 0;
        return m;
    endfunction

    function automatic bit hazard_m(int i);
        m_t e;
        e = st[i][0];
        return e.mr && (e.dest != 0) && (e.dest == rs || e.dest == rt);
    endfunction

    function automatic logic [19:0] exp_vec(int i);
        m_t d, e, m, w;
        bit hz, s, f;
        d = dec_m(i);
        e = st[i][0]; m = st[i][1]; w = st[i][2];
        hz = hazard_m(i);
        s = hz && !br;
        f = br || (d.jmp && !hz);
        return {d.jmp, d.ext, s, f, d.ill, e.alusrc, e.regdst, e.branch, e.bne, e.aluop,
                m.mr, m.mw, w.rw, w.m2r, w.dest};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 3; k++) st[i][k] <= '0;
                cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st[i][2] <= st[i][1];
                st[i][1] <= st[i][0];
                st[i][0] <= (br || hazard_m(i)) ? m_t'(0) : dec_m(i);
                if (hazard_m(i) && !br && cnt[i] < ((i == 0) ? 32'd65535 : 32'd3))
                    cnt[i] <= cnt[i] + 1;
            end
        end
    end

    // Compare process: every falling edge, both instances, all outputs.
    always @(negedge clk) begin
        chk("dut0 outputs", {12'b0, obs0}, {12'b0, exp_vec(0)});
        chk("dut1 outputs", {12'b0, obs1}, {12'b0, exp_vec(1)});
        chk("dut0 stallcnt", {16'b0, a_cnt}, cnt[0]);
        chk("dut1 stallcnt", {30'b0, b_cnt}, cnt[1]);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic b, input logic r);
        @(posedge clk);
        #2;
        op = o; rs = s; rt = t; rd = d; br = b; rst = r;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    logic [5:0] ops [10];
    int seq [5];

    initial begin
        rst = 1'b1; op = R; rs = 0; rt = 0; rd = 0; br = 0;
        ops = '{R, J, BEQ, BNE, ADDI, ORI, LW, SW, 6'b111111, 6'b000011};
        seq = '{1, 2, 3, 3, 3};
        repeat (2) @(posedge clk);
        probe();
        chk("reset regs dut0", {17'b0, obs0[14:0]}, 0);
        chk("reset cnt dut0", {16'b0, a_cnt}, 0);
        step(R, 0, 0, 0, 0, 0);

        // load-use stall: lw $8 then add rs=8
        step(LW, 1, 8, 0, 0, 0);
        step(R, 8, 9, 10, 0, 0);
        probe(); chk("t1 stall", {31'b0, a_stall}, 1);
        step(R, 8, 9, 10, 0, 0);
        probe();
        chk("t1 stall released", {31'b0, a_stall}, 0);
        chk("t1 ex bubble", {26'b0, a_alusrc, a_regdst, a_branch, a_bne, a_aluop}, 0);
        chk("t1 stallcnt", {16'b0, a_cnt}, 1);
        chk("t1 lw in mem", {31'b0, a_mr}, 1);
        step(R, 0, 0, 0, 0, 0);
        probe(); chk("t1 add in ex", {31'b0, a_regdst}, 1);
        step(R, 0, 0, 0, 0, 0);
        step(R, 0, 0, 0, 0, 0);
        probe();
        chk("t1 add wb reg", {27'b0, a_wreg}, 10);
        chk("t1 add wb write", {31'b0, a_rw}, 1);

        // lw to $0: no hazard, no write
        step(LW, 0, 0, 5, 0, 0);
        step(R, 0, 0, 3, 0, 0);
        probe(); chk("t2 no stall", {31'b0, a_stall}, 0);
        step(R, 0, 0, 0, 0, 0);
        step(R, 0, 0, 0, 0, 0);
        probe(); chk("t2 lw wb write", {31'b0, a_rw}, 0);

        // taken branch overrides a load-use hazard
        step(LW, 2, 7, 0, 0, 0);
        step(LW, 7, 4, 0, 1, 0);
        probe();
        chk("t3 flush", {31'b0, a_flush}, 1);
        chk("t3 stall", {31'b0, a_stall}, 0);
        step(R, 0, 0, 0, 0, 0);
        probe();
        chk("t3 ex bubble", {26'b0, a_alusrc, a_regdst, a_branch, a_bne, a_aluop}, 0);
        chk("t3 stallcnt", {16'b0, a_cnt}, 1);

        // ori in both configurations
        step(ORI, 1, 2, 0, 0, 0);
        probe();
        chk("t4 ori extop", {31'b0, a_ext}, 0);
        chk("t4 ori legal", {31'b0, a_ill}, 0);
        chk("t4 ori illegal dut1", {31'b0, b_ill}, 1);
        step(R, 0, 0, 0, 0, 0);
        probe();
        chk("t4 ori aluop", {30'b0, a_aluop}, 3);
        chk("t4 dut1 ex zero", {26'b0, b_alusrc, b_regdst, b_branch, b_bne, b_aluop}, 0);

        // jump alone flushes; jump under a stall does not
        step(J, 0, 0, 0, 0, 0);
        probe(); chk("jump flush", {30'b0, a_jump, a_flush}, 2'b11);
        step(LW, 0, 6, 0, 0, 0);
        step(J, 6, 0, 0, 0, 0);
        probe(); chk("jump stalled", {30'b0, a_stall, a_flush}, 2'b10);

        // async reset mid-stall with a full pipeline
        step(LW, 1, 9, 0, 0, 0);
        step(SW, 0, 0, 0, 0, 0);
        step(R, 1, 2, 3, 0, 0);
        step(LW, 3, 11, 0, 0, 0);
        step(R, 11, 0, 12, 0, 0);
        probe(); chk("t6 stall before reset", {31'b0, a_stall}, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6 rst regs dut0", {17'b0, obs0[14:0]}, 0);
        chk("t6 rst regs dut1", {17'b0, obs1[14:0]}, 0);
        chk("t6 rst cnt dut0", {16'b0, a_cnt}, 0);
        chk("t6 rst cnt dut1", {30'b0, b_cnt}, 0);

        // 2-bit counter saturation over five stalls
        for (int k = 0; k < 5; k++) begin
            step(LW, 0, 8, 0, 0, 0);
            step(R, 8, 0, 1, 0, 0);
            step(R, 8, 0, 1, 0, 0);
            probe(); chk("t5 cnt2 sequence", {30'b0, b_cnt}, seq[k]);
        end

        // randomized traffic with a small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            step(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 499) == 0));
        end
        probe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
